// File: rtl/spi_cs_sequencer.sv
// Multi-byte SPI transaction sequencer: owns CS_n, feeds bytes to the byte engine and returns indexed RX bytes.
// First byte issues CS_SETUP_CLKS cycles after CS_n falls; host is stalled via o_TX_Ready and issue waits for i_Byte_TX_Ready.
module spi_cs_sequencer #(
    parameter int MAX_BYTES_PER_CS = 8,
    parameter int CS_SETUP_CLKS    = 2,
    parameter int CS_HOLD_CLKS     = 2,
    parameter int CS_INACTIVE_CLKS = 1,
    parameter int CW               = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic          i_Clk,
    input  logic          i_Rst_L,
    input  logic [CW-1:0] i_TX_Count,
    input  logic [7:0]    i_TX_Byte,
    input  logic          i_TX_DV,
    output logic          o_TX_Ready,
    output logic [CW-1:0] o_RX_Count,
    output logic          o_RX_DV,
    output logic [7:0]    o_RX_Byte,
    output logic [7:0]    o_Byte_TX_Byte,
    output logic          o_Byte_TX_DV,
    input  logic          i_Byte_TX_Ready,
    input  logic          i_Byte_RX_DV,
    input  logic [7:0]    i_Byte_RX_Byte,
    output logic          o_SPI_CS_n
);

    localparam int TMAX = (CS_SETUP_CLKS > CS_HOLD_CLKS)
        ? ((CS_SETUP_CLKS > CS_INACTIVE_CLKS) ? CS_SETUP_CLKS : CS_INACTIVE_CLKS)
        : ((CS_HOLD_CLKS  > CS_INACTIVE_CLKS) ? CS_HOLD_CLKS  : CS_INACTIVE_CLKS);
    localparam int TW = $clog2(TMAX + 1);

    localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP_CLKS - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(CS_HOLD_CLKS - 1);
    localparam logic [TW-1:0] INACT_LAST = TW'(CS_INACTIVE_CLKS - 1);
    localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_BYTES_PER_CS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_WAIT_RX,
        S_WAIT_HOST,
        S_HOLD,
        S_INACTIVE
    } state_t;

    state_t        state, next_state;
    logic          run;
    logic [TW-1:0] timer;
    logic [CW-1:0] remaining;
    logic [CW-1:0] count_clamped;
    logic          accept;
    logic          rx_take;
    logic          timer_run;

    // run holds o_TX_Ready low while reset is asserted and for the first edge after release
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state <= S_IDLE;
            run   <= 1'b0;
        end else begin
            state <= next_state;
            run   <= 1'b1;
        end
    end

    always_comb begin
        next_state   = state;
        o_TX_Ready   = 1'b0;
        o_Byte_TX_DV = 1'b0;
        rx_take      = 1'b0;
        timer_run    = 1'b0;
        case (state)
            S_IDLE: begin
                o_TX_Ready = run & i_Byte_TX_Ready;
                if (i_TX_DV && o_TX_Ready) next_state = S_SETUP;
            end
            S_SETUP: begin
                timer_run = 1'b1;
                if (timer == SETUP_LAST) next_state = S_ISSUE;
            end
            S_ISSUE: begin
                if (i_Byte_TX_Ready) begin
                    o_Byte_TX_DV = 1'b1;
                    next_state   = S_WAIT_RX;
                end
            end
            S_WAIT_RX: begin
                if (i_Byte_RX_DV) begin
                    rx_take    = 1'b1;
                    next_state = (remaining != '0) ? S_WAIT_HOST : S_HOLD;
                end
            end
            S_WAIT_HOST: begin
                o_TX_Ready = 1'b1;
                if (i_TX_DV) next_state = S_ISSUE;
            end
            S_HOLD: begin
                timer_run = 1'b1;
                if (timer == HOLD_LAST) next_state = S_INACTIVE;
            end
            S_INACTIVE: begin
                timer_run = 1'b1;
                if (timer == INACT_LAST) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign accept = i_TX_DV & o_TX_Ready;

    always_comb begin
        count_clamped = i_TX_Count;
        if (i_TX_Count == '0)          count_clamped = CW'(1);
        else if (i_TX_Count > MAX_CNT) count_clamped = MAX_CNT;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            timer          <= '0;
            remaining      <= '0;
            o_Byte_TX_Byte <= '0;
            o_RX_DV        <= 1'b0;
            o_RX_Byte      <= '0;
            o_RX_Count     <= '0;
            o_SPI_CS_n     <= 1'b1;
        end else begin
            timer   <= (timer_run && next_state == state) ? timer + TW'(1) : '0;
            o_RX_DV <= rx_take;

            if (accept) o_Byte_TX_Byte <= i_TX_Byte;

            if (state == S_IDLE && accept) begin
                remaining  <= count_clamped;
                o_RX_Count <= '0;
                o_SPI_CS_n <= 1'b0;
            end else if (o_RX_DV) begin
                o_RX_Count <= o_RX_Count + CW'(1);
            end

            if (o_Byte_TX_DV) remaining <= remaining - CW'(1);
            if (rx_take)      o_RX_Byte <= i_Byte_RX_Byte;
            if (state == S_HOLD && next_state == S_INACTIVE) o_SPI_CS_n <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_cs_sequencer.sv
// Directed bench for spi_cs_sequencer with a loopback byte-engine model and CS/RX timing monitor.
module tb_spi_cs_sequencer;
    localparam int CW = 4;

    logic          i_Clk = 1'b0;
    logic          i_Rst_L = 1'b0;
    logic [CW-1:0] tx_count = '0;
    logic [7:0]    tx_byte = '0;
    logic          tx_dv = 1'b0;
    logic          tx_ready;
    logic [CW-1:0] rx_count;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic [7:0]    eng_tx_byte;
    logic          eng_tx_dv;
    logic          eng_rdy = 1'b1;
    logic          eng_rx_dv = 1'b0;
    logic [7:0]    eng_rx_byte = '0;
    logic          cs_n;

    spi_cs_sequencer dut (
        .i_Clk           (i_Clk),
        .i_Rst_L         (i_Rst_L),
        .i_TX_Count      (tx_count),
        .i_TX_Byte       (tx_byte),
        .i_TX_DV         (tx_dv),
        .o_TX_Ready      (tx_ready),
        .o_RX_Count      (rx_count),
        .o_RX_DV         (rx_dv),
        .o_RX_Byte       (rx_byte),
        .o_Byte_TX_Byte  (eng_tx_byte),
        .o_Byte_TX_DV    (eng_tx_dv),
        .i_Byte_TX_Ready (eng_rdy),
        .i_Byte_RX_DV    (eng_rx_dv),
        .i_Byte_RX_Byte  (eng_rx_byte),
        .o_SPI_CS_n      (cs_n)
    );

    always #5 i_Clk = ~i_Clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: sampled 1 time unit after the falling edge
    int         cyc = 0;
    int         cs_rises = 0, cs_falls = 0, rdy_lo = 0;
    int         last_fall = 0, last_rise = 0;
    bit         prev_cs = 1'b1;
    logic [7:0] rx_q[$];
    int         rxc_q[$];
    int         rxcyc_q[$];
    logic [7:0] iss_q[$];
    int         isscyc_q[$];

    always @(posedge i_Clk) cyc <= cyc + 1;

    always @(negedge i_Clk) begin
        #1;
        if (rx_dv) begin
            rx_q.push_back(rx_byte);
            rxc_q.push_back(int'(rx_count));
            rxcyc_q.push_back(cyc);
        end
        if (eng_tx_dv) begin
            iss_q.push_back(eng_tx_byte);
            isscyc_q.push_back(cyc);
        end
        if (prev_cs && !cs_n) begin cs_falls++; last_fall = cyc; end
        if (!prev_cs && cs_n) begin cs_rises++; last_rise = cyc; end
        prev_cs = cs_n;
        if (tx_ready && !cs_n) rdy_lo++;
    end

    function automatic logic [7:0] rxb(int i);
        return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
    endfunction
    function automatic int rxc(int i);
        return (i < rxc_q.size()) ? rxc_q[i] : -1;
    endfunction
    function automatic int rxcyc(int i);
        return (i < rxcyc_q.size()) ? rxcyc_q[i] : -1;
    endfunction
    function automatic logic [7:0] issb(int i);
        return (i < iss_q.size()) ? iss_q[i] : 8'hxx;
    endfunction
    function automatic int isscyc(int i);
        return (i < isscyc_q.size()) ? isscyc_q[i] : -1;
    endfunction

    // Byte engine: busy one cycle after the start pulse, returns the same byte (loopback) 4 cycles later
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge i_Clk);
            if (eng_tx_dv) begin
                b = eng_tx_byte;
                @(negedge i_Clk);
                eng_rdy = 1'b0;
                repeat (3) @(negedge i_Clk);
                eng_rx_dv   = 1'b1;
                eng_rx_byte = b;
                @(negedge i_Clk);
                eng_rx_dv = 1'b0;
                eng_rdy   = 1'b1;
            end
        end
    end

    task automatic host_send(input string tag, input logic [CW-1:0] cnt, input logic [7:0] b, input int stall);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (tx_ready) begin ok = 1'b1; break; end
            @(negedge i_Clk);
        end
        chk({tag, "_rdy"}, 32'(ok), 1);
        repeat (stall) @(negedge i_Clk);
        tx_count = cnt;
        tx_byte  = b;
        tx_dv    = 1'b1;
        @(negedge i_Clk);
        tx_dv = 1'b0;
    endtask

    task automatic stray_pulse(input logic [CW-1:0] cnt, input logic [7:0] b);
        tx_count = cnt;
        tx_byte  = b;
        tx_dv    = 1'b1;
        @(negedge i_Clk);
        tx_dv = 1'b0;
    endtask

    task automatic wait_rise(input string tag, input int base);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge i_Clk);
            #2;
            if (cs_rises > base) begin ok = 1'b1; break; end
        end
        @(negedge i_Clk);
        chk({tag, "_done"}, 32'(ok), 1);
    endtask

    task automatic wait_eng(input string tag, input logic lvl);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge i_Clk);
            #2;
            if (eng_rdy == lvl) begin ok = 1'b1; break; end
        end
        chk({tag, "_eng"}, 32'(ok), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b_rx, b_iss, b_rise, b_fall, b_rdy;

        // Reset state
        repeat (2) @(negedge i_Clk);
        #1;
        chk("rst_cs_n", 32'(cs_n), 1);
        chk("rst_tx_ready", 32'(tx_ready), 0);
        chk("rst_rx_dv", 32'(rx_dv), 0);
        chk("rst_rx_byte", 32'(rx_byte), 0);
        chk("rst_rx_count", 32'(rx_count), 0);
        chk("rst_eng_dv", 32'(eng_tx_dv), 0);
        chk("rst_eng_byte", 32'(eng_tx_byte), 0);
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        repeat (2) @(negedge i_Clk);

        // 1: single byte, setup/hold timing
        b_rx = rx_q.size(); b_iss = iss_q.size(); b_rise = cs_rises;
        host_send("t1", 4'd1, 8'hA5, 0);
        wait_rise("t1", b_rise);
        chk("t1_nrx", rx_q.size() - b_rx, 1);
        chk("t1_rx_byte", 32'(rxb(b_rx)), 32'hA5);
        chk("t1_rx_count", rxc(b_rx), 0);
        chk("t1_setup_gap", isscyc(b_iss) - last_fall, 2);
        chk("t1_hold_gap", last_rise - rxcyc(b_rx), 2);

        // 2: three back-to-back bytes under one CS window; later counts ignored
        b_rx = rx_q.size(); b_iss = iss_q.size(); b_rise = cs_rises; b_fall = cs_falls;
        host_send("t2a", 4'd3, 8'h11, 0);
        host_send("t2b", 4'd7, 8'h22, 0);
        host_send("t2c", 4'd7, 8'h33, 0);
        wait_rise("t2", b_rise);
        chk("t2_niss", iss_q.size() - b_iss, 3);
        chk("t2_nrx", rx_q.size() - b_rx, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t2_rx_byte%0d", i), 32'(rxb(b_rx + i)), 32'(8'h11 * (i + 1)));
            chk($sformatf("t2_rx_count%0d", i), rxc(b_rx + i), i);
        end
        chk("t2_falls", cs_falls - b_fall, 1);
        chk("t2_rises", cs_rises - b_rise, 1);

        // 3: host stalls 50 clocks before byte 2
        b_rx = rx_q.size(); b_rise = cs_rises; b_fall = cs_falls; b_rdy = rdy_lo;
        host_send("t3a", 4'd2, 8'h5C, 0);
        host_send("t3b", 4'd2, 8'hC5, 50);
        wait_rise("t3", b_rise);
        chk("t3_ready_window", rdy_lo - b_rdy, 51);
        chk("t3_falls", cs_falls - b_fall, 1);
        chk("t3_rises", cs_rises - b_rise, 1);
        chk("t3_rx_byte1", 32'(rxb(b_rx + 1)), 32'hC5);
        chk("t3_rx_count1", rxc(b_rx + 1), 1);

        // 4: i_TX_DV during SETUP and WAIT_RX is dropped
        b_rx = rx_q.size(); b_iss = iss_q.size(); b_rise = cs_rises; b_fall = cs_falls;
        host_send("t4", 4'd1, 8'h5A, 0);
        stray_pulse(4'd5, 8'hFF);
        wait_eng("t4", 1'b0);
        stray_pulse(4'd5, 8'hEE);
        wait_rise("t4", b_rise);
        chk("t4_niss", iss_q.size() - b_iss, 1);
        chk("t4_iss_byte", 32'(issb(b_iss)), 32'h5A);
        chk("t4_nrx", rx_q.size() - b_rx, 1);
        chk("t4_rx_byte", 32'(rxb(b_rx)), 32'h5A);
        chk("t4_falls", cs_falls - b_fall, 1);

        // 5a: count 0 behaves as count 1
        b_rx = rx_q.size(); b_iss = iss_q.size(); b_rise = cs_rises;
        host_send("t5a", 4'd0, 8'h3C, 0);
        wait_rise("t5a", b_rise);
        chk("t5a_niss", iss_q.size() - b_iss, 1);
        chk("t5a_rx_byte", 32'(rxb(b_rx)), 32'h3C);
        chk("t5a_rx_count", rxc(b_rx), 0);

        // 5b: count MAX+3 clamps to MAX (8)
        b_rx = rx_q.size(); b_iss = iss_q.size(); b_rise = cs_rises;
        host_send("t5b", 4'd11, 8'h80, 0);
        for (int i = 1; i < 8; i++) host_send("t5b_n", 4'd11, 8'(8'h80 + i), 0);
        wait_rise("t5b", b_rise);
        chk("t5b_niss", iss_q.size() - b_iss, 8);
        chk("t5b_nrx", rx_q.size() - b_rx, 8);
        chk("t5b_last_byte", 32'(rxb(b_rx + 7)), 32'h87);
        chk("t5b_last_count", rxc(b_rx + 7), 7);
        chk("t5b_rises", cs_rises - b_rise, 1);

        // 6: reset while byte 2 of 3 is in flight
        b_rx = rx_q.size(); b_iss = iss_q.size();
        host_send("t6a", 4'd3, 8'h41, 0);
        host_send("t6b", 4'd3, 8'h42, 0);
        wait_eng("t6", 1'b0);
        i_Rst_L = 1'b0;
        #1;
        chk("t6_cs_n", 32'(cs_n), 1);
        chk("t6_tx_ready", 32'(tx_ready), 0);
        chk("t6_rx_dv", 32'(rx_dv), 0);
        repeat (3) @(negedge i_Clk);
        i_Rst_L = 1'b1;
        wait_eng("t6r", 1'b1);
        repeat (3) @(negedge i_Clk);
        chk("t6_nrx_after_rst", rx_q.size() - b_rx, 1);
        chk("t6_rx_byte0", 32'(rxb(b_rx)), 32'h41);
        b_rise = cs_rises;
        host_send("t6c", 4'd1, 8'h77, 0);
        wait_rise("t6c", b_rise);
        chk("t6_nrx_total", rx_q.size() - b_rx, 2);
        chk("t6_next_byte", 32'(rxb(b_rx + 1)), 32'h77);
        chk("t6_next_count", rxc(b_rx + 1), 0);
        chk("t6_niss", iss_q.size() - b_iss, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
